// File: rtl/pe_meas_sched.sv
// Batch sequencer: streams N_SIGMA sigma points into the measurement processor and
// collects the in-order results. Define PE_MEAS_SCHED_STATS_EN to add the lat_cyc port.
module pe_meas_sched #(
  parameter int unsigned N_SIGMA   = 11,
  parameter int unsigned PRIME_CYC = 2,
  parameter int unsigned FLUSH_CYC = 26,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          sp_valid,
  output logic          sp_ready,
  input  logic [159:0]  sp_data,
  output logic          mp_en_clk,
  output logic [159:0]  mp_state,
  output logic          mp_state_valid,
  input  logic [63:0]   mp_meas,
  input  logic          mp_meas_valid,
  output logic          res_valid,
  output logic [3:0]    res_idx,
  output logic [63:0]   res_data,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef PE_MEAS_SCHED_STATS_EN
  ,
  output logic [15:0]   lat_cyc
`endif
);

  localparam int unsigned SP_W   = 160;
  localparam int unsigned MEAS_W = 64;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned FL_W   = $clog2(FLUSH_CYC + 1);
  localparam int unsigned PR_W   = $clog2(PRIME_CYC + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SIGMA);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_ISSUE, S_DRAIN, S_FLUSH, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
  logic [PR_W-1:0]     prime_cnt_q, prime_cnt_d;
  logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]     wd_q, wd_d, wd_inc;
  logic                err_q, err_d;
  logic [SP_W-1:0]     mp_state_q, mp_state_d;
  logic                mp_state_valid_q, mp_state_valid_d;
  logic                res_valid_q, res_valid_d;
  logic [CNT_W-1:0]    res_idx_q, res_idx_d;
  logic [MEAS_W-1:0]   res_data_q, res_data_d;
  logic                act_q, act_d;
  logic                done_q, done_d;
  logic                hs, collect_win, cap, stray;

  // Abort drops ready combinationally so no state slips in on the abort cycle.
  assign sp_ready    = (state_q == S_ISSUE) && (issue_cnt_q < N_CNT) && !abort;
  assign hs          = sp_valid && sp_ready;
  assign collect_win = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !abort;
  assign cap         = collect_win && mp_meas_valid && (ret_cnt_q < N_CNT);
  assign stray       = mp_meas_valid &&
                       ((state_q == S_IDLE) || (state_q == S_PRIME) || (state_q == S_DONE) ||
                        (collect_win && (ret_cnt_q == N_CNT)));
  assign wd_inc      = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);

  // Next-state, counters and datapath.
  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    prime_cnt_d      = prime_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    wd_d             = wd_q;
    err_d            = err_q;
    mp_state_d       = mp_state_q;
    mp_state_valid_d = 1'b0;
    res_valid_d      = 1'b0;
    res_idx_d        = res_idx_q;
    res_data_d       = res_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PRIME;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          prime_cnt_d = '0;
          flush_cnt_d = '0;
          wd_d        = '0;
          err_d       = 1'b0;
        end
      end
      S_PRIME: begin
        if (abort) begin
          state_d = S_FLUSH;
        end else if (prime_cnt_q == PR_W'(PRIME_CYC - 1)) begin
          state_d     = S_ISSUE;
          prime_cnt_d = '0;
        end else begin
          prime_cnt_d = prime_cnt_q + PR_W'(1);
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_FLUSH;
        end else if (hs && (issue_cnt_q == N_CNT - CNT_W'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        wd_d = cap ? '0 : wd_inc;
        if (abort) begin
          state_d = S_FLUSH;
        end else if (ret_cnt_q == N_CNT) begin
          state_d = S_DONE;
        end else if (!cap && (wd_inc == WD_W'(TIMEOUT))) begin
          err_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FL_W'(FLUSH_CYC - 1)) begin
          state_d     = S_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (hs) begin
      mp_state_d       = sp_data;
      mp_state_valid_d = 1'b1;
      issue_cnt_d      = issue_cnt_q + CNT_W'(1);
    end
    if (cap) begin
      res_valid_d = 1'b1;
      res_idx_d   = ret_cnt_q;
      res_data_d  = mp_meas;
      ret_cnt_d   = ret_cnt_q + CNT_W'(1);
    end
    if (stray) begin
      err_d = 1'b1;
    end
  end

  assign act_d  = state_d inside {S_PRIME, S_ISSUE, S_DRAIN, S_FLUSH};
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      issue_cnt_q      <= '0;
      ret_cnt_q        <= '0;
      prime_cnt_q      <= '0;
      flush_cnt_q      <= '0;
      wd_q             <= '0;
      err_q            <= 1'b0;
      mp_state_q       <= '0;
      mp_state_valid_q <= 1'b0;
      res_valid_q      <= 1'b0;
      res_idx_q        <= '0;
      res_data_q       <= '0;
      act_q            <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_cnt_q      <= issue_cnt_d;
      ret_cnt_q        <= ret_cnt_d;
      prime_cnt_q      <= prime_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
      wd_q             <= wd_d;
      err_q            <= err_d;
      mp_state_q       <= mp_state_d;
      mp_state_valid_q <= mp_state_valid_d;
      res_valid_q      <= res_valid_d;
      res_idx_q        <= res_idx_d;
      res_data_q       <= res_data_d;
      act_q            <= act_d;
      done_q           <= done_d;
    end
  end

  assign mp_en_clk      = act_q;
  assign busy           = act_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mp_state       = mp_state_q;
  assign mp_state_valid = mp_state_valid_q;
  assign res_valid      = res_valid_q;
  assign res_idx        = res_idx_q;
  assign res_data       = res_data_q;

`ifdef PE_MEAS_SCHED_STATS_EN
  logic [15:0] lat_cnt_q, lat_cnt_d;
  logic [15:0] lat_q, lat_d;

  // Busy-cycle count of the batch, published alongside the done pulse.
  always_comb begin
    lat_cnt_d = lat_cnt_q;
    lat_d     = lat_q;
    if ((state_q == S_IDLE) && start) begin
      lat_cnt_d = '0;
    end else if (act_q && (lat_cnt_q != 16'hFFFF)) begin
      lat_cnt_d = lat_cnt_q + 16'(1);
    end
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      lat_d = lat_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q <= '0;
      lat_q     <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      lat_q     <= lat_d;
    end
  end

  assign lat_cyc = lat_q;
`endif

endmodule

// File: tb/tb_pe_meas_sched.sv
// Scoreboard bench for pe_meas_sched with a 24-cycle measurement-processor model.
`timescale 1ns/1ps
module tb_pe_meas_sched;

  localparam int unsigned N     = 11;
  localparam int unsigned LAT   = 24;
  localparam int unsigned TMO   = 64;
  localparam int unsigned FLUSH = 26;

  typedef struct packed {
    logic [3:0]  idx;
    logic [63:0] meas;
  } exp_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         start    = 1'b0;
  logic         abort    = 1'b0;
  logic         sp_valid = 1'b0;
  logic [159:0] sp_data  = '0;
  logic         sp_ready, mp_en_clk, mp_state_valid, res_valid, busy, done, err;
  logic [159:0] mp_state;
  logic [63:0]  mp_meas;
  logic         mp_meas_valid;
  logic [3:0]   res_idx;
  logic [63:0]  res_data;
`ifdef PE_MEAS_SCHED_STATS_EN
  logic [15:0]  lat_cyc;
`endif

  logic         mdl_valid = 1'b0;
  logic [63:0]  mdl_meas  = '0;
  logic         stray_inj = 1'b0;
  logic         pv [LAT];
  logic [63:0]  pd [LAT];
  int           drop_idx = -1;
  int           st_cnt   = 0;

  exp_t         sb_q[$];
  logic [159:0] iq[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, res_cnt = 0, done_cnt = 0, last_res_cyc = 0, err_rise_cyc = 0, busy_cyc = 0;
  logic err_prev = 1'b0;

  pe_meas_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .sp_valid       (sp_valid),
    .sp_ready       (sp_ready),
    .sp_data        (sp_data),
    .mp_en_clk      (mp_en_clk),
    .mp_state       (mp_state),
    .mp_state_valid (mp_state_valid),
    .mp_meas        (mp_meas),
    .mp_meas_valid  (mp_meas_valid),
    .res_valid      (res_valid),
    .res_idx        (res_idx),
    .res_data       (res_data),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef PE_MEAS_SCHED_STATS_EN
    ,
    .lat_cyc        (lat_cyc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] meas_of(input logic [159:0] s);
    return {s[31:0] ^ 32'hA5A5_0F0F, s[159:128]};
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Processor model: fixed latency, clock-enabled, optional dropped result.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LAT); i++) pv[i] = 1'b0;
      mdl_valid = 1'b0;
      st_cnt    = 0;
    end else if (mp_en_clk) begin
      mdl_valid = pv[LAT-1];
      mdl_meas  = pd[LAT-1];
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = mp_state_valid && (st_cnt != drop_idx);
      pd[0] = meas_of(mp_state);
      if (mp_state_valid) st_cnt++;
    end else begin
      mdl_valid = 1'b0;
      st_cnt    = 0;
    end
  end

  assign mp_meas_valid = mdl_valid | stray_inj;
  assign mp_meas       = mdl_meas;

  // Output monitor: issue mirror, result scoreboard, done timing.
  always @(negedge clk) begin
    logic [159:0] s;
    exp_t         e;
    cyc++;
    if (mp_state_valid) begin
      if (iq.size() == 0) chk("state_valid_unexp", 160'(mp_state_valid), 160'(0));
      else begin
        s = iq.pop_front();
        chk("mp_state", mp_state, s);
      end
    end
    if (res_valid) begin
      res_cnt++;
      last_res_cyc = cyc;
      if (sb_q.size() == 0) chk("res_unexp", 160'(res_valid), 160'(0));
      else begin
        e = sb_q.pop_front();
        chk("res_idx", 160'(res_idx), 160'(e.idx));
        chk("res_data", 160'(res_data), 160'(e.meas));
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_gap", 160'(cyc - last_res_cyc), 160'(1));
`ifdef PE_MEAS_SCHED_STATS_EN
      chk("lat_cyc", 160'(lat_cyc), 160'(busy_cyc));
`endif
    end
    if (err && !err_prev) err_rise_cyc = cyc;
    err_prev = err;
    if (busy) busy_cyc++;
    else if (!done) busy_cyc = 0;
  end

  task automatic check_reset_outputs();
    chk("rst_sp_ready", 160'(sp_ready), 160'(0));
    chk("rst_en_clk", 160'(mp_en_clk), 160'(0));
    chk("rst_mp_state", mp_state, 160'(0));
    chk("rst_state_valid", 160'(mp_state_valid), 160'(0));
    chk("rst_res_valid", 160'(res_valid), 160'(0));
    chk("rst_res_idx", 160'(res_idx), 160'(0));
    chk("rst_res_data", 160'(res_data), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_err", 160'(err), 160'(0));
`ifdef PE_MEAS_SCHED_STATS_EN
    chk("rst_lat_cyc", 160'(lat_cyc), 160'(0));
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 160'(busy), 160'(1));
    chk("start_err_clr", 160'(err), 160'(0));
    chk("prime_no_ready", 160'(sp_ready), 160'(0));
  endtask

  // Drives the sigma-point stream and records expected issues/results.
  task automatic feed(input bit toggle, input int abort_after, output bit aborted);
    int   sent, pushed, n;
    bit   tog;
    exp_t e;
    sent = 0; pushed = 0; n = 0; tog = 1'b1; aborted = 1'b0;
    while (sent < int'(N) && n < 200) begin
      @(negedge clk);
      n++;
      sp_valid = toggle ? tog : 1'b1;
      tog      = ~tog;
      sp_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (sent == abort_after) abort = 1'b1;
      #1;
      if (abort) begin
        chk("sp_ready_on_abort", 160'(sp_ready), 160'(0));
        sb_q.delete();
        aborted = 1'b1;
        break;
      end
      if (sp_valid && sp_ready) begin
        iq.push_back(sp_data);
        if (sent != drop_idx) begin
          e.idx  = 4'(pushed);
          e.meas = meas_of(sp_data);
          sb_q.push_back(e);
          pushed++;
        end
        sent++;
      end
    end
    if (!aborted) begin
      chk("feed_complete", 160'(sent), 160'(N));
      @(negedge clk);
      sp_valid = 1'b0;
    end
  endtask

  task automatic run_clean(input bit toggle);
    int d0, r0, n;
    bit ab;
    d0 = done_cnt; r0 = res_cnt;
    do_start();
    feed(toggle, -1, ab);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 160'(done), 160'(1));
    chk("done_err", 160'(err), 160'(0));
    @(negedge clk);
    chk("done_one_cycle", 160'(done), 160'(0));
    chk("idle_busy", 160'(busy), 160'(0));
    chk("batch_res_cnt", 160'(res_cnt - r0), 160'(N));
    chk("batch_sb_empty", 160'(sb_q.size()), 160'(0));
    chk("batch_done_cnt", 160'(done_cnt - d0), 160'(1));
  endtask

  initial begin
    int d0, r0, n;
    bit ab;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_clean(1'b0);
    run_clean(1'b1);

    // Result 7 never returns: watchdog expiry, flush, no done.
    drop_idx = 7; d0 = done_cnt; r0 = res_cnt;
    do_start();
    feed(1'b0, -1, ab);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_err", 160'(err), 160'(1));
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_flush_len", 160'(n), 160'(FLUSH));
    chk("timeout_wd_gap", 160'(err_rise_cyc - last_res_cyc), 160'(TMO));
    chk("timeout_res_cnt", 160'(res_cnt - r0), 160'(N - 1));
    chk("timeout_no_done", 160'(done_cnt - d0), 160'(0));
    chk("timeout_sb_empty", 160'(sb_q.size()), 160'(0));
    chk("timeout_en_off", 160'(mp_en_clk), 160'(0));
    drop_idx = -1;

    // Abort after five issues; in-flight results must be swallowed.
    d0 = done_cnt; r0 = res_cnt;
    do_start();
    feed(1'b0, 5, ab);
    chk("abort_taken", 160'(ab), 160'(1));
    @(negedge clk);
    abort = 1'b0; sp_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("abort_flush_len", 160'(n), 160'(FLUSH));
    chk("abort_no_res", 160'(res_cnt - r0), 160'(0));
    chk("abort_no_done", 160'(done_cnt - d0), 160'(0));
    chk("abort_no_err", 160'(err), 160'(0));
    run_clean(1'b0);

    // Stray result in IDLE.
    @(negedge clk);
    stray_inj = 1'b1;
    @(negedge clk);
    stray_inj = 1'b0;
    chk("stray_err", 160'(err), 160'(1));
    chk("stray_no_res", 160'(res_valid), 160'(0));
    run_clean(1'b0);

    // Asynchronous reset in the middle of DRAIN.
    r0 = res_cnt;
    do_start();
    feed(1'b0, -1, ab);
    n = 0;
    while (res_cnt < r0 + 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_busy", 160'(busy), 160'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb_q.delete();
    iq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_clean(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
